// File: rtl/aliens_grid_engine.sv
// aliens_grid_engine: alien formation march, multi-laser hit resolution,
// saturating score, sticky victory/defeat and registered alien pixel colour.
// Optional feature macro: ALIEN_SPEEDUP_EN doubles the horizontal step once
// a quarter or fewer of the aliens survive.
module aliens_grid_engine #(
    parameter int NB_LIN    = 4,
    parameter int NB_COL    = 8,
    parameter int NB_LASERS = 2,
    parameter int ALIEN_W   = 32,
    parameter int ALIEN_H   = 24,
    parameter int PITCH_X   = 48,
    parameter int PITCH_Y   = 32,
    parameter int STEP_X    = 4,
    parameter int STEP_Y    = 16,
    parameter int X_START   = 64,
    parameter int Y_START   = 40,
    parameter int SCREEN_W  = 640,
    parameter int DEFEAT_Y  = 420,
    parameter int SCORE_W   = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [9:0]                  hPos,
    input  logic [9:0]                  vPos,
    input  logic [10*NB_LASERS-1:0]     xLaser,
    input  logic [10*NB_LASERS-1:0]     yLaser,
    input  logic [NB_LASERS-1:0]        laserActive,
    output logic [NB_LASERS-1:0]        killingAlien,
    output logic [NB_LIN*NB_COL-1:0]    alive,
    output logic signed [10:0]          xAlien,
    output logic [9:0]                  yAlien,
    output logic [2:0]                  colorAlien,
    output logic [SCORE_W-1:0]          score,
    output logic                        victory,
    output logic                        defeat
);

    localparam int NB_ALIENS = NB_LIN * NB_COL;
    localparam int KCNT_W    = $clog2(NB_LASERS + 1);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WON  = 2'd1,
        LOST = 2'd2
    } state_t;

    state_t                   state;
    logic                     dir;

    logic signed [11:0]       x_org;
    logic signed [11:0]       y_org;
    logic [NB_ALIENS-1:0]     kill_mask;
    logic [NB_LASERS-1:0]     kill_pulse;
    logic [KCNT_W-1:0]        kill_cnt;
    logic [SCORE_W:0]         score_sum;
    logic [SCORE_W-1:0]       score_next;
    logic [NB_COL-1:0]        col_any;
    logic [NB_LIN-1:0]        row_any;
    logic signed [11:0]       left_x;
    logic signed [11:0]       right_x;
    logic signed [11:0]       bottom_y;
    logic signed [11:0]       step;
    logic                     descend;
    logic [2:0]               color_next;

    assign x_org = {xAlien[10], xAlien};
    assign y_org = {2'b00, yAlien};

    function automatic logic in_box(
        input logic signed [11:0] px,
        input logic signed [11:0] py,
        input logic signed [11:0] ox,
        input logic signed [11:0] oy,
        input int                 r,
        input int                 c
    );
        logic signed [11:0] lx;
        logic signed [11:0] ly;
        lx = ox + $signed(12'(c * PITCH_X));
        ly = oy + $signed(12'(r * PITCH_Y));
        return (px >= lx) && (px < lx + $signed(12'(ALIEN_W))) &&
               (py >= ly) && (py < ly + $signed(12'(ALIEN_H)));
    endfunction

    // Resolve laser hits on the current mask; a lower channel claims an alien first
    always_comb begin
        kill_mask  = '0;
        kill_pulse = '0;
        for (int i = 0; i < NB_LASERS; i++) begin
            for (int a = 0; a < NB_ALIENS; a++) begin
                if (laserActive[i] && alive[a] &&
                    in_box({2'b00, xLaser[10*i +: 10]}, {2'b00, yLaser[10*i +: 10]},
                           x_org, y_org, a / NB_COL, a % NB_COL)) begin
                    if (!kill_mask[a]) begin
                        kill_pulse[i] = 1'b1;
                    end
                    kill_mask[a] = 1'b1;
                end
            end
        end
    end

    // Count kills this cycle and add them to the score, clamping at all-ones
    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < NB_LASERS; i++) begin
            kill_cnt = kill_cnt + KCNT_W'(kill_pulse[i]);
        end
        score_sum  = {1'b0, score} + (SCORE_W + 1)'(kill_cnt);
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

`ifdef ALIEN_SPEEDUP_EN
    localparam int CNT_W = $clog2(NB_ALIENS + 1);
    logic [CNT_W-1:0] alive_cnt;

    // Count survivors on the current mask to choose the march speed
    always_comb begin
        alive_cnt = '0;
        for (int a = 0; a < NB_ALIENS; a++) begin
            alive_cnt = alive_cnt + CNT_W'(alive[a]);
        end
        step = (alive_cnt <= CNT_W'(NB_ALIENS / 4)) ? $signed(12'(2 * STEP_X))
                                                     : $signed(12'(STEP_X));
    end
`else
    assign step = $signed(12'(STEP_X));
`endif

    // Derive the formation's live edges and decide whether this tick descends
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < NB_LIN; r++) begin
            for (int c = 0; c < NB_COL; c++) begin
                if (alive[r*NB_COL + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
        left_x   = x_org;
        right_x  = x_org + $signed(12'(ALIEN_W));
        bottom_y = y_org + $signed(12'(ALIEN_H));
        for (int c = NB_COL - 1; c >= 0; c--) begin
            if (col_any[c]) left_x = x_org + $signed(12'(c * PITCH_X));
        end
        for (int c = 0; c < NB_COL; c++) begin
            if (col_any[c]) right_x = x_org + $signed(12'(c * PITCH_X + ALIEN_W));
        end
        for (int r = 0; r < NB_LIN; r++) begin
            if (row_any[r]) bottom_y = y_org + $signed(12'(r * PITCH_Y + ALIEN_H));
        end
        if (dir) begin
            descend = (left_x - step) < 12'sd0;
        end else begin
            descend = (right_x + step) > $signed(12'(SCREEN_W));
        end
    end

    // Flag whether the current pixel falls inside any surviving alien
    always_comb begin
        color_next = 3'b000;
        for (int a = 0; a < NB_ALIENS; a++) begin
            if (alive[a] && in_box({2'b00, hPos}, {2'b00, vPos}, x_org, y_org,
                                   a / NB_COL, a % NB_COL)) begin
                color_next = 3'b010;
            end
        end
    end

    // Game FSM: end checks first, then hits, score and movement while playing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= PLAY;
            dir          <= 1'b0;
            alive        <= '1;
            xAlien       <= 11'(X_START);
            yAlien       <= 10'(Y_START);
            score        <= '0;
            killingAlien <= '0;
            victory      <= 1'b0;
            defeat       <= 1'b0;
        end else begin
            killingAlien <= '0;
            case (state)
                PLAY: begin
                    if (alive == '0) begin
                        state   <= WON;
                        victory <= 1'b1;
                    end else if (bottom_y >= $signed(12'(DEFEAT_Y))) begin
                        state  <= LOST;
                        defeat <= 1'b1;
                    end else begin
                        killingAlien <= kill_pulse;
                        alive        <= alive & ~kill_mask;
                        score        <= score_next;
                        if (tick) begin
                            if (descend) begin
                                yAlien <= yAlien + 10'(STEP_Y);
                                dir    <= ~dir;
                            end else if (dir) begin
                                xAlien <= xAlien - step[10:0];
                            end else begin
                                xAlien <= xAlien + step[10:0];
                            end
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    // Register the pixel colour for one cycle of latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colorAlien <= 3'b000;
        end else begin
            colorAlien <= color_next;
        end
    end

endmodule

// File: tb/tb_aliens_grid_engine.sv
// tb_aliens_grid_engine: randomized scoreboard bench for aliens_grid_engine
// against a behavioural game model (honours ALIEN_SPEEDUP_EN).
module tb_aliens_grid_engine;

    localparam int NB_LIN    = 4;
    localparam int NB_COL    = 8;
    localparam int NB_LASERS = 2;
    localparam int ALIEN_W   = 32;
    localparam int ALIEN_H   = 24;
    localparam int PITCH_X   = 48;
    localparam int PITCH_Y   = 32;
    localparam int STEP_X    = 4;
    localparam int STEP_Y    = 16;
    localparam int X_START   = 64;
    localparam int Y_START   = 40;
    localparam int SCREEN_W  = 640;
    localparam int DEFEAT_Y  = 420;
    localparam int SCORE_W   = 12;
    localparam int NB        = NB_LIN * NB_COL;
`ifdef ALIEN_SPEEDUP_EN
    localparam int FAST_STEP = 2 * STEP_X;
`else
    localparam int FAST_STEP = STEP_X;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                tick = 1'b0;
    logic [9:0]          hPos = '0;
    logic [9:0]          vPos = '0;
    logic [19:0]         xLaser = '0;
    logic [19:0]         yLaser = '0;
    logic [1:0]          laserActive = '0;
    logic [1:0]          killingAlien;
    logic [NB-1:0]       alive;
    logic signed [10:0]  xAlien;
    logic [9:0]          yAlien;
    logic [2:0]          colorAlien;
    logic [SCORE_W-1:0]  score;
    logic                victory;
    logic                defeat;

    aliens_grid_engine #(
        .NB_LIN(NB_LIN), .NB_COL(NB_COL), .NB_LASERS(NB_LASERS),
        .ALIEN_W(ALIEN_W), .ALIEN_H(ALIEN_H), .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y),
        .STEP_X(STEP_X), .STEP_Y(STEP_Y), .X_START(X_START), .Y_START(Y_START),
        .SCREEN_W(SCREEN_W), .DEFEAT_Y(DEFEAT_Y), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .hPos(hPos), .vPos(vPos),
        .xLaser(xLaser), .yLaser(yLaser), .laserActive(laserActive),
        .killingAlien(killingAlien), .alive(alive), .xAlien(xAlien), .yAlien(yAlien),
        .colorAlien(colorAlien), .score(score), .victory(victory), .defeat(defeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    kill;
        logic [NB-1:0] mask;
        int            x;
        int            y;
        int            score;
        logic          vic;
        logic          def;
        logic [2:0]    color;
    } exp_t;

    exp_t sb[$];
    int   checks_total = 0;
    int   checks_passed = 0;

    // Game model: mode 0 playing, 1 won, 2 lost
    int   m_x, m_y, m_dir, m_score, m_mode;
    bit   m_alive[NB];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_x = X_START; m_y = Y_START; m_dir = 0; m_score = 0; m_mode = 0;
        foreach (m_alive[a]) m_alive[a] = 1'b1;
    endtask

    function automatic bit model_hit(input int px, input int py, input int a);
        int r, c;
        r = a / NB_COL;
        c = a % NB_COL;
        return m_alive[a] &&
               px >= m_x + c * PITCH_X && px < m_x + c * PITCH_X + ALIEN_W &&
               py >= m_y + r * PITCH_Y && py < m_y + r * PITCH_Y + ALIEN_H;
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (m_alive[a]) if (m_alive[a]) n++;
        return n;
    endfunction

    function automatic logic [NB-1:0] model_mask();
        logic [NB-1:0] m;
        foreach (m_alive[a]) m[a] = m_alive[a];
        return m;
    endfunction

    function automatic int clamp10(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    task automatic model_step(input bit t, input int lx0, input int ly0, input int lx1,
                              input int ly1, input bit [1:0] act, input int h, input int v,
                              output exp_t e);
        int  lx[2], ly[2];
        int  cmin, cmax, rmax, cnt, kills, step;
        bit  dead[NB];
        lx[0] = lx0; ly[0] = ly0; lx[1] = lx1; ly[1] = ly1;
        e.kill  = 2'b00;
        e.color = 3'b000;
        for (int a = 0; a < NB; a++) if (model_hit(h, v, a)) e.color = 3'b010;
        cnt = model_count();
        cmin = NB_COL; cmax = -1; rmax = -1;
        for (int a = 0; a < NB; a++) begin
            if (m_alive[a]) begin
                if (a % NB_COL < cmin) cmin = a % NB_COL;
                if (a % NB_COL > cmax) cmax = a % NB_COL;
                if (a / NB_COL > rmax) rmax = a / NB_COL;
            end
        end
        if (m_mode == 0) begin
            if (cnt == 0) begin
                m_mode = 1;
            end else if (m_y + rmax * PITCH_Y + ALIEN_H >= DEFEAT_Y) begin
                m_mode = 2;
            end else begin
                kills = 0;
                foreach (dead[a]) dead[a] = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (act[i]) begin
                        for (int a = 0; a < NB; a++) begin
                            if (model_hit(lx[i], ly[i], a) && !dead[a]) begin
                                dead[a]   = 1'b1;
                                e.kill[i] = 1'b1;
                                kills++;
                            end
                        end
                    end
                end
                if (t) begin
                    step = (cnt <= NB / 4) ? FAST_STEP : STEP_X;
                    if (m_dir == 0) begin
                        if (m_x + cmax * PITCH_X + ALIEN_W + step > SCREEN_W) begin
                            m_y += STEP_Y; m_dir = 1;
                        end else begin
                            m_x += step;
                        end
                    end else begin
                        if (m_x + cmin * PITCH_X - step < 0) begin
                            m_y += STEP_Y; m_dir = 0;
                        end else begin
                            m_x -= step;
                        end
                    end
                end
                foreach (dead[a]) if (dead[a]) m_alive[a] = 1'b0;
                m_score = (m_score + kills > (1 << SCORE_W) - 1) ? (1 << SCORE_W) - 1
                                                                 : m_score + kills;
            end
        end
        e.mask  = model_mask();
        e.x     = m_x;
        e.y     = m_y;
        e.score = m_score;
        e.vic   = (m_mode == 1);
        e.def   = (m_mode == 2);
    endtask

    // Drive one cycle at the falling edge, push the model's answer, wait a cycle
    task automatic applyStimulus(input bit t, input int x0, input int y0, input int x1,
                                 input int y1, input bit [1:0] act, input int h, input int v);
        exp_t e;
        x0 = clamp10(x0); y0 = clamp10(y0); x1 = clamp10(x1); y1 = clamp10(y1);
        tick        = t;
        xLaser      = {10'(x1), 10'(x0)};
        yLaser      = {10'(y1), 10'(y0)};
        laserActive = act;
        hPos        = 10'(h);
        vPos        = 10'(v);
        model_step(t, x0, y0, x1, y1, act, h, v, e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic quiet_cycle(input bit t);
        applyStimulus(t, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 2'b00,
                      int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    endtask

    function automatic int rand_alive();
        int n, k;
        n = model_count();
        if (n == 0) return -1;
        k = int'($urandom_range(0, n - 1));
        for (int a = 0; a < NB; a++) begin
            if (m_alive[a]) begin
                if (k == 0) return a;
                k--;
            end
        end
        return -1;
    endfunction

    // Tip coordinates on alien a; with slop the tip may land just outside the box
    task automatic aim(input int a, input bit slop, output int px, output int py);
        int r, c;
        r = a / NB_COL;
        c = a % NB_COL;
        if (slop) begin
            px = m_x + c * PITCH_X - 2 + int'($urandom_range(0, ALIEN_W + 3));
            py = m_y + r * PITCH_Y - 2 + int'($urandom_range(0, ALIEN_H + 3));
        end else begin
            px = m_x + c * PITCH_X + int'($urandom_range(0, ALIEN_W - 1));
            py = m_y + r * PITCH_Y + int'($urandom_range(0, ALIEN_H - 1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick = 1'b0;
        laserActive = 2'b00;
        model_reset();
        #1;
        checkOutput("rst_alive", longint'(alive), longint'({NB{1'b1}}));
        checkOutput("rst_x", longint'(xAlien), X_START);
        checkOutput("rst_y", longint'(yAlien), Y_START);
        checkOutput("rst_score", longint'(score), 0);
        checkOutput("rst_kill", longint'(killingAlien), 0);
        checkOutput("rst_color", longint'(colorAlien), 0);
        checkOutput("rst_flags", longint'({victory, defeat}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pop and compare one expectation per clock after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("killingAlien", longint'(killingAlien), longint'(e.kill));
                checkOutput("alive", longint'(alive), longint'(e.mask));
                checkOutput("xAlien", longint'(xAlien), e.x);
                checkOutput("yAlien", longint'(yAlien), e.y);
                checkOutput("score", longint'(score), e.score);
                checkOutput("victory", longint'(victory), longint'(e.vic));
                checkOutput("defeat", longint'(defeat), longint'(e.def));
                checkOutput("colorAlien", longint'(colorAlien), longint'(e.color));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int px0, py0, px1, py1, n, a0, a1, won_x;
        bit [1:0] act;
        #2;
        do_reset();

        // Marching: ten ticks, then up to the right-edge descent
        for (int i = 0; i < 10; i++) begin
            quiet_cycle(1'b1);
            quiet_cycle(1'b0);
        end
        checkOutput("x_after_10_ticks", longint'(xAlien), 104);
        n = 0;
        while (m_y == Y_START && n < 200) begin
            quiet_cycle(1'b1);
            n++;
        end
        checkOutput("descent_y", longint'(yAlien), 56);
        checkOutput("descent_x", longint'(xAlien), 272);

        // Same alien under both channels, then two distinct aliens
        do_reset();
        applyStimulus(1'b0, 70, 45, 70, 45, 2'b11, 0, 0);
        checkOutput("overlap_kill", longint'(killingAlien), 1);
        checkOutput("overlap_alive0", longint'(alive[0]), 0);
        checkOutput("overlap_score", longint'(score), 1);
        do_reset();
        applyStimulus(1'b0, 70, 45, 118, 45, 2'b11, 0, 0);
        checkOutput("distinct_kill", longint'(killingAlien), 3);
        checkOutput("distinct_score", longint'(score), 2);
        quiet_cycle(1'b0);

        // Random play with a mid-game reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            act = 2'($urandom_range(0, 3));
            px0 = int'($urandom_range(0, 1023)); py0 = int'($urandom_range(0, 1023));
            px1 = int'($urandom_range(0, 1023)); py1 = int'($urandom_range(0, 1023));
            a0 = rand_alive();
            a1 = rand_alive();
            if (a0 >= 0 && $urandom_range(0, 3) != 0) aim(a0, 1'b1, px0, py0);
            if (a1 >= 0 && $urandom_range(0, 3) != 0) aim(a1, 1'b1, px1, py1);
            if ($urandom_range(0, 4) == 0) begin px1 = px0; py1 = py0; end
            applyStimulus($urandom_range(0, 2) == 0, px0, py0, px1, py1, act,
                          int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end

        // Victory: shoot every alien, then confirm the formation freezes
        do_reset();
        n = 0;
        while (m_mode == 0 && n < 300) begin
            a0 = rand_alive();
            a1 = rand_alive();
            px0 = 0; py0 = 0; px1 = 0; py1 = 0;
            if (a0 >= 0) aim(a0, 1'b0, px0, py0);
            if (a1 >= 0) aim(a1, 1'b0, px1, py1);
            applyStimulus($urandom_range(0, 3) == 0, px0, py0, px1, py1, 2'b11,
                          int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
            n++;
        end
        checkOutput("victory_flag", longint'(victory), 1);
        checkOutput("victory_alive", longint'(alive), 0);
        won_x = m_x;
        for (int i = 0; i < 8; i++) quiet_cycle(1'b1);
        checkOutput("won_x_frozen", longint'(xAlien), won_x);

        // Defeat: ticks only until the formation crosses the invasion line
        do_reset();
        n = 0;
        while (m_mode == 0 && n < 3000) begin
            quiet_cycle(1'b1);
            n++;
        end
        checkOutput("defeat_flag", longint'(defeat), 1);
        checkOutput("defeat_no_victory", longint'(victory), 0);
        for (int i = 0; i < 5; i++) begin
            a0 = rand_alive();
            aim(a0, 1'b0, px0, py0);
            applyStimulus(1'b1, px0, py0, px0, py0, 2'b11, 0, 0);
        end
        checkOutput("lost_no_pulse", longint'(killingAlien), 0);
        checkOutput("lost_score", longint'(score), 0);

        // Speed threshold: nine survivors march at the base step, eight may go faster
        do_reset();
        for (int a = 8; a <= 30; a += 2) begin
            aim(a, 1'b0, px0, py0);
            px1 = 0; py1 = 0;
            if (a + 1 <= 30) aim(a + 1, 1'b0, px1, py1);
            applyStimulus(1'b0, px0, py0, px1, py1, (a + 1 <= 30) ? 2'b11 : 2'b01, 0, 0);
        end
        quiet_cycle(1'b1);
        checkOutput("nine_left_step", longint'(xAlien), X_START + STEP_X);
        aim(31, 1'b0, px0, py0);
        applyStimulus(1'b0, px0, py0, 0, 0, 2'b01, 0, 0);
        quiet_cycle(1'b1);
        checkOutput("eight_left_step", longint'(xAlien), X_START + STEP_X + FAST_STEP);

        quiet_cycle(1'b0);
        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/aliens_grid_engine.md
# aliens_grid_engine

Parametrised alien-formation engine: holds an NB_LIN x NB_COL grid of aliens, marches it left/right and down on a movement tick, resolves hits from up to NB_LASERS laser channels, keeps score, and raises sticky victory/defeat. It sits between the tick/laser units and the final colour mixer. It replaces the fixed 2x2, single-laser motion/colour pair with one block, and adds multi-laser hits, scoring and a registered pixel colour.

## Interface
- NB_LIN, 4, alien rows
- NB_COL, 8, alien columns
- NB_LASERS, 2, laser channels
- ALIEN_W / ALIEN_H, 32 / 24, alien size in pixels
- PITCH_X / PITCH_Y, 48 / 32, cell pitch (must be ≥ size)
- STEP_X / STEP_Y, 4 / 16, horizontal and descent step in pixels
- X_START / Y_START, 64 / 40, reset position of the top-left cell
- SCREEN_W, 640, right edge limit (exclusive)
- DEFEAT_Y, 420, invasion line
- SCORE_W, 12, score width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-cycle movement pulse
- hPos, vPos  in  10 each  current VGA pixel
- xLaser, yLaser  in  10*NB_LASERS each  laser tip; channel i is bits [10i+9:10i]
- laserActive  in  NB_LASERS  channel i is in flight
- killingAlien  out  NB_LASERS  one-cycle pulse: channel i hit an alien
- alive  out  NB_LIN*NB_COL  bit r*NB_COL+c = alien (r,c) alive
- xAlien  out  11 signed  grid origin x
- yAlien  out  10  grid origin y
- colorAlien  out  3  pixel colour, registered
- score  out  SCORE_W  kill count, saturating
- victory, defeat  out  1 each  sticky end flags

## Operation
- FSM: PLAY, WON, LOST. Reset enters PLAY. WON and LOST are terminal until reset; in them, tick and lasers are ignored and killingAlien stays 0.
- Alien (r,c) box: x in [xAlien+c*PITCH_X, +ALIEN_W), y in [yAlien+r*PITCH_Y, +ALIEN_H). Bounds are inclusive-exclusive.
- Hit: channel i with laserActive[i] whose tip lies in an alive box.
  - Overlapping hits on the same alien: the lowest channel index wins and the others do not pulse.
  - Distinct aliens hit in the same cycle all die.
  - Hit tests use the pre-update position and alive mask.
- score increments by the number of aliens killed that cycle and saturates at all-ones.
- Edges are computed from the alive mask:
  - leftX: left edge of the leftmost alive column.
  - rightX: right edge of the rightmost alive column.
  - bottomY: bottom edge of the lowest alive row.
- Direction register dir: 0 = right, 1 = left; reset value 0.
- On tick in PLAY:
  - Moving right: if rightX+step > SCREEN_W, descend (yAlien += STEP_Y, dir flips, no x move); otherwise xAlien += step.
  - Moving left: if leftX−step < 0, descend and flip dir; otherwise xAlien −= step.
- End conditions:
  - alive becomes all-zero: next state WON and victory=1.
  - Otherwise, if bottomY ≥ DEFEAT_Y after an update: LOST and defeat=1.
  - Victory has priority over defeat.
- colorAlien = 3'b010 when (hPos,vPos) is inside an alive box, else 3'b000.
- xAlien is signed 11-bit; all comparisons are done in 12-bit signed arithmetic.

## Timing
- Reset values:
  - alive all ones, xAlien=X_START, yAlien=Y_START, dir=0, score=0.
  - killingAlien=0, colorAlien=0, victory=0, defeat=0.
- Hit detected in cycle n: killingAlien pulses, alive bit clears and score updates at edge n+1.
- Movement: position updates at the edge following tick.
- colorAlien: one cycle of latency from hPos/vPos.
- victory/defeat: assert one cycle after the causing update.
- Reset mid-game: all state returns to reset values immediately; in-flight pulses are dropped.

## Configuration
- ALIEN_SPEEDUP_EN defined: step = 2*STEP_X once the alive count ≤ (NB_LIN*NB_COL)/4, evaluated on the pre-update mask.
- Not defined: step = STEP_X always, and no popcount logic is built.

## Test plan
- Reset, sample with no tick: alive=32'hFFFFFFFF, xAlien=64, yAlien=40, score=0, all flags 0.
- 10 ticks, no lasers: xAlien=104. Drive ticks until rightX+4 > 640: that tick gives yAlien=56, dir=1 and xAlien unchanged.
- Channels 0 and 1 both at (70,45), active: killingAlien=2'b01, alive[0]=0, score=1. Repeat with channel 1 on alien (0,1) at (118,45): killingAlien=2'b11, score=2.
- Kill all 32 aliens: victory=1 one cycle after the last kill; further ticks leave xAlien frozen.
- Ticks only until bottomY ≥ 420: defeat=1, FSM in LOST, later hits produce no pulse.
- With ALIEN_SPEEDUP_EN, leave 8 aliens alive: the next tick moves xAlien by 8; without the macro it moves by 4.
